e203_itcm_arb_ctrl: RTL and testbench
=====================================

Name: e203_itcm_arb_ctrl

Overview:
- Two-requester arbiter and sequencer in front of the ITCM SRAM wrapper (cs/we/addr/wem/din/dout, one-cycle read latency).
- Shares the single SRAM port between the IFU fetch path and the LSU load/store path.
- Uses valid/ready command and response channels, and holds read data when a response is back-pressured.
- Drives the SRAM low-power pins.

Parameters:
- AW, 13, SRAM word-address width.
- DW, 64, SRAM data width.
- MW, 8, byte-mask width (DW/8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_cmd_valid / ifu_cmd_ready  in/out  1  IFU command handshake
- ifu_cmd_addr  in  AW  IFU word address (read-only requester)
- ifu_rsp_valid / ifu_rsp_ready  out/in  1  IFU response handshake
- ifu_rsp_rdata  out  DW  IFU read data
- lsu_cmd_valid / lsu_cmd_ready  in/out  1  LSU command handshake
- lsu_cmd_read  in  1  1 = read, 0 = write
- lsu_cmd_addr  in  AW  LSU word address
- lsu_cmd_wdata  in  DW  write data
- lsu_cmd_wmask  in  MW  byte write enables
- lsu_rsp_valid / lsu_rsp_ready  out/in  1  LSU response handshake
- lsu_rsp_rdata  out  DW  read data; 0 for writes
- ram_cs, ram_we  out  1  SRAM chip select, write enable
- ram_addr  out  AW  SRAM address
- ram_wem  out  MW  SRAM byte mask
- ram_din  out  DW  SRAM write data
- ram_dout  in  DW  SRAM read data
- ram_sd, ram_ds, ram_ls  out  1  SRAM shutdown, deep-sleep, light-sleep

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - all rsp_valid = 0; ram_cs = 0; ram_we = 0; ram_sd/ram_ds/ram_ls = 0.
  - last_grant = IFU, so LSU wins the first tie.
  - hold registers = 0; idle counter = 0.
- Arbitration:
  - Round-robin between requesters whose cmd_valid = 1 and whose response slot is free.
  - A slot is free when rsp_valid = 0, or when rsp_valid && rsp_ready in the same cycle.
  - The winner gets cmd_ready = 1 (combinational); the loser gets 0.
  - At most one grant per cycle. last_grant updates only on an accepted command.
- SRAM drive on an accepted command (same cycle):
  - ram_cs = 1; ram_addr = winner addr.
  - ram_we = ~lsu_cmd_read for LSU, 0 for IFU.
  - ram_wem = lsu_cmd_wmask on writes, otherwise 0; ram_din = lsu_cmd_wdata.
  - When no command is accepted, ram_cs = 0.
- Response timing:
  - rsp_valid rises the cycle after acceptance (latency 1) and stays high until rsp_ready.
  - First response cycle: rdata = ram_dout (bypass), and ram_dout is captured into a per-requester hold register.
  - Later stalled cycles: rdata = hold register.
  - Hold data must stay stable even though the SRAM is accessed by the other requester.
  - Writes respond with rdata = 0.
- Back-to-back: with rsp_ready held at 1, one requester may issue a command every cycle (full throughput).
- Simultaneous response drain and new grant for the same requester is allowed: rsp_valid stays 1 and the data is the new word.
- Reset mid-transaction drops any in-flight response. No SRAM write is partially retried: the write already occurred on the cs cycle.
- ram_sd and ram_ds are tied 0.
- ram_ls behaviour is set by the optional feature below.

Optional Feature:
- Macro: E203_ITCM_ARB_LS_IDLE_EN.
- Defined:
  - A 4-bit idle counter increments each cycle with no cmd_valid and no pending rsp_valid, saturating at 15.
  - Any cmd_valid clears the counter.
  - ram_ls = 1 when counter = 15.
  - While ram_ls = 1, both cmd_ready are forced to 0 for the cycle in which cmd_valid first appears. ram_ls then drops and the grant occurs the next cycle (1-cycle wake penalty).
- Undefined: ram_ls = 0 constantly; no wake penalty.

Test Plan:
1. Reset, then LSU write addr 0x10, wdata 0x1122334455667788, wmask 0xFF, then IFU read 0x10 -> LSU rsp rdata 0 at cycle+1; IFU rsp rdata 0x1122334455667788 one cycle after its grant.
2. Both cmd_valid every cycle, rsp_ready = 1 -> grants alternate LSU, IFU, LSU, …; first grant LSU; ram_cs high every cycle.
3. IFU read 0x20 (holding 0xA5A5…), ifu_rsp_ready = 0 for 5 cycles while LSU writes 0x20 with 0x0 -> ifu_rsp_rdata stays 0xA5A5… all 5 cycles; IFU cmd_ready stays 0 until drain.
4. Partial write wmask 0x0F with wdata 0xFFFF… over 0x0 -> read-back 0x00000000FFFFFFFF.
5. rst_n asserted with lsu_rsp_valid pending -> lsu_rsp_valid = 0 immediately (asynchronously); after release, the first tie grants LSU.
6. With E203_ITCM_ARB_LS_IDLE_EN defined: 16 idle cycles -> ram_ls = 1; IFU cmd_valid -> ready 0 for 1 cycle, ram_ls = 0, grant the next cycle.

Source files
------------

// File: rtl/e203_itcm_arb_ctrl_if.sv
// Bus bundle for the ITCM arbiter: IFU/LSU command+response channels and the SRAM port.
// slave = arbiter view, master = requesters + SRAM view.
interface e203_itcm_arb_ctrl_if #(
  parameter int AW = 13,
  parameter int DW = 64,
  parameter int MW = 8
);
  logic          ifu_cmd_valid;
  logic          ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic          ifu_rsp_valid;
  logic          ifu_rsp_ready;
  logic [DW-1:0] ifu_rsp_rdata;

  logic          lsu_cmd_valid;
  logic          lsu_cmd_ready;
  logic          lsu_cmd_read;
  logic [AW-1:0] lsu_cmd_addr;
  logic [DW-1:0] lsu_cmd_wdata;
  logic [MW-1:0] lsu_cmd_wmask;
  logic          lsu_rsp_valid;
  logic          lsu_rsp_ready;
  logic [DW-1:0] lsu_rsp_rdata;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_sd;
  logic          ram_ds;
  logic          ram_ls;

  modport slave (
    input  ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
    output ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata,
    input  lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_wmask, lsu_rsp_ready,
    output lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata,
    output ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_sd, ram_ds, ram_ls,
    input  ram_dout
  );

  modport master (
    output ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
    input  ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata,
    output lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_wmask, lsu_rsp_ready,
    input  lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_sd, ram_ds, ram_ls,
    output ram_dout
  );
endinterface

// File: rtl/e203_itcm_arb_ctrl.sv
// Round-robin IFU/LSU arbiter for the ITCM SRAM with per-requester response hold.
// Optional E203_ITCM_ARB_LS_IDLE_EN: idle counter drives ram_ls with a 1-cycle wake penalty.
module e203_itcm_arb_ctrl #(
  parameter int AW = 13,
  parameter int DW = 64,
  parameter int MW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e203_itcm_arb_ctrl_if.slave  bus
);
  logic          r_last_lsu;
  logic          r_ifu_rsp_valid, r_lsu_rsp_valid;
  logic          r_ifu_first, r_lsu_first;
  logic          r_lsu_rd;
  logic [DW-1:0] r_ifu_hold, r_lsu_hold;

  logic w_ifu_free, w_lsu_free, w_ifu_req, w_lsu_req;
  logic w_gnt_ifu, w_gnt_lsu, w_we, w_ls;

`ifdef E203_ITCM_ARB_LS_IDLE_EN
  logic [3:0] r_idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idle_cnt <= 4'd0;
    else if (bus.ifu_cmd_valid || bus.lsu_cmd_valid)
      r_idle_cnt <= 4'd0;
    else if (!r_ifu_rsp_valid && !r_lsu_rsp_valid && (r_idle_cnt != 4'hF))
      r_idle_cnt <= r_idle_cnt + 4'd1;
  end

  // While asleep, the first cmd_valid only wakes the SRAM; grants resume next cycle.
  assign w_ls = (r_idle_cnt == 4'hF);
`else
  assign w_ls = 1'b0;
`endif

  assign w_ifu_free = ~r_ifu_rsp_valid | bus.ifu_rsp_ready;
  assign w_lsu_free = ~r_lsu_rsp_valid | bus.lsu_rsp_ready;
  assign w_ifu_req  = bus.ifu_cmd_valid & w_ifu_free & ~w_ls;
  assign w_lsu_req  = bus.lsu_cmd_valid & w_lsu_free & ~w_ls;

  // On a tie, whoever was not granted last wins.
  assign w_gnt_ifu = w_ifu_req & (~w_lsu_req |  r_last_lsu);
  assign w_gnt_lsu = w_lsu_req & (~w_ifu_req | ~r_last_lsu);
  assign w_we      = w_gnt_lsu & ~bus.lsu_cmd_read;

  assign bus.ifu_cmd_ready = w_gnt_ifu;
  assign bus.lsu_cmd_ready = w_gnt_lsu;

  assign bus.ram_cs   = w_gnt_ifu | w_gnt_lsu;
  assign bus.ram_we   = w_we;
  assign bus.ram_addr = w_gnt_lsu ? bus.lsu_cmd_addr : bus.ifu_cmd_addr;
  assign bus.ram_wem  = w_we ? bus.lsu_cmd_wmask : '0;
  assign bus.ram_din  = bus.lsu_cmd_wdata;
  assign bus.ram_sd   = 1'b0;
  assign bus.ram_ds   = 1'b0;
  assign bus.ram_ls   = w_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_lsu      <= 1'b0;
      r_ifu_rsp_valid <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_ifu_first     <= 1'b0;
      r_lsu_first     <= 1'b0;
      r_lsu_rd        <= 1'b0;
      r_ifu_hold      <= '0;
      r_lsu_hold      <= '0;
    end else begin
      if (w_gnt_ifu)      r_last_lsu <= 1'b0;
      else if (w_gnt_lsu) r_last_lsu <= 1'b1;

      if (w_gnt_ifu)              r_ifu_rsp_valid <= 1'b1;
      else if (bus.ifu_rsp_ready) r_ifu_rsp_valid <= 1'b0;
      if (w_gnt_lsu)              r_lsu_rsp_valid <= 1'b1;
      else if (bus.lsu_rsp_ready) r_lsu_rsp_valid <= 1'b0;

      r_ifu_first <= w_gnt_ifu;
      r_lsu_first <= w_gnt_lsu;
      if (w_gnt_lsu) r_lsu_rd <= bus.lsu_cmd_read;

      // ram_dout is only ours on the first response cycle; freeze it for stalls.
      if (r_ifu_first) r_ifu_hold <= bus.ram_dout;
      if (r_lsu_first) r_lsu_hold <= bus.ram_dout;
    end
  end

  assign bus.ifu_rsp_valid = r_ifu_rsp_valid;
  assign bus.lsu_rsp_valid = r_lsu_rsp_valid;
  assign bus.ifu_rsp_rdata = r_ifu_first ? bus.ram_dout : r_ifu_hold;
  assign bus.lsu_rsp_rdata = ~r_lsu_rd  ? '0 :
                             r_lsu_first ? bus.ram_dout : r_lsu_hold;
endmodule

// File: tb/tb_e203_itcm_arb_ctrl.sv
// Directed table-driven bench for e203_itcm_arb_ctrl with a 1-cycle-latency SRAM model.
module tb_e203_itcm_arb_ctrl;
  localparam logic [63:0] A = 64'h1122334455667788;
  localparam logic [63:0] P = 64'hA5A5A5A5A5A5A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  e203_itcm_arb_ctrl_if #(.AW(13), .DW(64), .MW(8)) bus ();
  e203_itcm_arb_ctrl #(.AW(13), .DW(64), .MW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [63:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) begin
        for (int b = 0; b < 8; b++)
          if (bus.ram_wem[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_din[b*8 +: 8];
      end else begin
        bus.ram_dout <= mem[bus.ram_addr];
      end
    end
  end

  typedef struct {
    logic iv; logic [12:0] ia; logic irr;
    logic lv; logic lr; logic [12:0] la; logic [63:0] lwd; logic [7:0] lwm; logic lrr;
    logic e_icr; logic e_lcr; logic e_cs; logic e_we; logic [12:0] e_addr; logic [7:0] e_wem;
    logic e_irv; logic [63:0] e_ird; logic e_lrv; logic [63:0] e_lrd;
  } vec_t;

  function automatic vec_t mk(
    logic iv, logic [12:0] ia, logic irr,
    logic lv, logic lr, logic [12:0] la, logic [63:0] lwd, logic [7:0] lwm, logic lrr,
    logic e_icr, logic e_lcr, logic e_cs, logic e_we, logic [12:0] e_addr, logic [7:0] e_wem,
    logic e_irv, logic [63:0] e_ird, logic e_lrv, logic [63:0] e_lrd);
    vec_t v;
    v.iv = iv; v.ia = ia; v.irr = irr;
    v.lv = lv; v.lr = lr; v.la = la; v.lwd = lwd; v.lwm = lwm; v.lrr = lrr;
    v.e_icr = e_icr; v.e_lcr = e_lcr; v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr;
    v.e_wem = e_wem; v.e_irv = e_irv; v.e_ird = e_ird; v.e_lrv = e_lrv; v.e_lrd = e_lrd;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.ifu_cmd_valid = v.iv;  bus.ifu_cmd_addr = v.ia;  bus.ifu_rsp_ready = v.irr;
    bus.lsu_cmd_valid = v.lv;  bus.lsu_cmd_read = v.lr;  bus.lsu_cmd_addr = v.la;
    bus.lsu_cmd_wdata = v.lwd; bus.lsu_cmd_wmask = v.lwm; bus.lsu_rsp_ready = v.lrr;
  endtask

  task automatic apply(string tag, int k, vec_t v);
    string s;
    @(negedge clk);
    drive(v);
    #1;
    s = $sformatf("%s[%0d]", tag, k);
    chk({s, ".ifu_cmd_ready"}, 64'(bus.ifu_cmd_ready), 64'(v.e_icr));
    chk({s, ".lsu_cmd_ready"}, 64'(bus.lsu_cmd_ready), 64'(v.e_lcr));
    chk({s, ".ram_cs"},        64'(bus.ram_cs),        64'(v.e_cs));
    chk({s, ".ram_we"},        64'(bus.ram_we),        64'(v.e_we));
    chk({s, ".ram_wem"},       64'(bus.ram_wem),       64'(v.e_wem));
    if (v.e_cs) chk({s, ".ram_addr"}, 64'(bus.ram_addr), 64'(v.e_addr));
    chk({s, ".ifu_rsp_valid"}, 64'(bus.ifu_rsp_valid), 64'(v.e_irv));
    chk({s, ".lsu_rsp_valid"}, 64'(bus.lsu_rsp_valid), 64'(v.e_lrv));
    if (v.e_irv) chk({s, ".ifu_rsp_rdata"}, bus.ifu_rsp_rdata, v.e_ird);
    if (v.e_lrv) chk({s, ".lsu_rsp_rdata"}, bus.lsu_rsp_rdata, v.e_lrd);
  endtask

  vec_t tbl [15];
  vec_t seq [9];
  vec_t idle;

  initial begin
    idle = mk(0,0,1, 0,1,0,0,0,1, 0,0,0,0,0,0, 0,0, 0,0);
    // preload, test 1, test 2, test 4
    tbl[0]  = mk(0,0,1,     1,0,13'h00,64'h0,8'hFF,1, 0,1,1,1,13'h00,8'hFF, 0,0, 0,0);
    tbl[1]  = mk(0,0,1,     1,0,13'h20,P,8'hFF,1,     0,1,1,1,13'h20,8'hFF, 0,0, 1,0);
    tbl[2]  = mk(0,0,1,     1,0,13'h10,A,8'hFF,1,     0,1,1,1,13'h10,8'hFF, 0,0, 1,0);
    tbl[3]  = mk(1,13'h10,1, 0,1,0,0,0,1,             1,0,1,0,13'h10,0,     0,0, 1,0);
    tbl[4]  = mk(0,0,1,     0,1,0,0,0,1,              0,0,0,0,0,0,          1,A, 0,0);
    tbl[5]  = idle;
    tbl[6]  = mk(1,13'h10,1, 1,1,13'h20,0,8'hFF,1,    0,1,1,0,13'h20,0,     0,0, 0,0);
    tbl[7]  = mk(1,13'h10,1, 1,1,13'h20,0,8'hFF,1,    1,0,1,0,13'h10,0,     0,0, 1,P);
    tbl[8]  = mk(1,13'h10,1, 1,1,13'h20,0,8'hFF,1,    0,1,1,0,13'h20,0,     1,A, 0,0);
    tbl[9]  = mk(1,13'h10,1, 1,1,13'h20,0,8'hFF,1,    1,0,1,0,13'h10,0,     0,0, 1,P);
    tbl[10] = mk(0,0,1,     0,1,0,0,0,1,              0,0,0,0,0,0,          1,A, 0,0);
    tbl[11] = mk(0,0,1,     1,0,13'h00,{64{1'b1}},8'h0F,1, 0,1,1,1,13'h00,8'h0F, 0,0, 0,0);
    tbl[12] = mk(0,0,1,     1,1,13'h00,0,8'hFF,1,     0,1,1,0,13'h00,0,     0,0, 1,0);
    tbl[13] = mk(0,0,1,     0,1,0,0,0,1,              0,0,0,0,0,0,          0,0, 1,64'h00000000FFFFFFFF);
    tbl[14] = idle;
    // test 3: IFU response stalled 5 cycles while LSU hits the SRAM
    seq[0] = mk(1,13'h20,0, 0,1,0,0,0,1,              1,0,1,0,13'h20,0,     0,0, 0,0);
    seq[1] = mk(1,13'h20,0, 1,0,13'h20,0,8'hFF,1,     0,1,1,1,13'h20,8'hFF, 1,P, 0,0);
    seq[2] = mk(1,13'h20,0, 1,1,13'h10,0,0,1,         0,1,1,0,13'h10,0,     1,P, 1,0);
    seq[3] = mk(1,13'h20,0, 0,1,0,0,0,1,              0,0,0,0,0,0,          1,P, 1,A);
    seq[4] = mk(1,13'h20,0, 0,1,0,0,0,1,              0,0,0,0,0,0,          1,P, 0,0);
    seq[5] = seq[4];
    seq[6] = mk(1,13'h20,1, 0,1,0,0,0,1,              1,0,1,0,13'h20,0,     1,P, 0,0);
    seq[7] = mk(0,0,1,     0,1,0,0,0,1,               0,0,0,0,0,0,          1,0, 0,0);
    seq[8] = idle;

    drive(idle);
    repeat (3) @(negedge clk);
    chk("rst.ifu_rsp_valid", 64'(bus.ifu_rsp_valid), 64'd0);
    chk("rst.lsu_rsp_valid", 64'(bus.lsu_rsp_valid), 64'd0);
    chk("rst.ram_cs", 64'(bus.ram_cs), 64'd0);
    chk("rst.ram_sleep", 64'({bus.ram_sd, bus.ram_ds, bus.ram_ls}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply("tbl", i, tbl[i]);
    for (int i = 0; i < 9; i++)  apply("hold", i, seq[i]);

    // test 5: async reset drops a pending LSU response
    apply("rstmid", 0, mk(0,0,1, 1,1,13'h00,0,0,0, 0,1,1,0,13'h00,0, 0,0, 0,0));
    apply("rstmid", 1, mk(0,0,1, 0,1,0,0,0,0, 0,0,0,0,0,0, 0,0, 1,64'h00000000FFFFFFFF));
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.lsu_rsp_valid", 64'(bus.lsu_rsp_valid), 64'd0);
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    apply("rstmid", 2, mk(1,13'h10,1, 1,1,13'h00,0,0,1, 0,1,1,0,13'h00,0, 0,0, 0,0));
    apply("rstmid", 3, mk(1,13'h10,1, 0,1,0,0,0,1,     1,0,1,0,13'h10,0, 0,0, 1,64'h00000000FFFFFFFF));
    apply("rstmid", 4, mk(0,0,1, 0,1,0,0,0,1,          0,0,0,0,0,0,      1,A, 0,0));

    // test 6: idle light-sleep and wake penalty
    repeat (17) @(negedge clk);
`ifdef E203_ITCM_ARB_LS_IDLE_EN
    chk("ls.asleep", 64'(bus.ram_ls), 64'd1);
    apply("ls", 0, mk(1,13'h10,1, 0,1,0,0,0,1, 0,0,0,0,0,0,      0,0, 0,0));
    chk("ls.still_asleep", 64'(bus.ram_ls), 64'd1);
    apply("ls", 1, mk(1,13'h10,1, 0,1,0,0,0,1, 1,0,1,0,13'h10,0, 0,0, 0,0));
    chk("ls.awake", 64'(bus.ram_ls), 64'd0);
`else
    chk("ls.off", 64'(bus.ram_ls), 64'd0);
    apply("ls", 0, mk(1,13'h10,1, 0,1,0,0,0,1, 1,0,1,0,13'h10,0, 0,0, 0,0));
    chk("ls.off_after", 64'(bus.ram_ls), 64'd0);
`endif
    apply("ls", 2, mk(0,0,1, 0,1,0,0,0,1, 0,0,0,0,0,0, 1,A, 0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
